stall_control: RTL and testbench

Pipeline stall and multiply/divide sequencing controller for the 5-stage core. It detects load-use hazards between F/D and D/X and inserts one bubble. It launches the shared multdiv unit for mul/div instructions held in D/X, freezes the front of the pipeline until the unit reports ready or times out, and holds the result for write into X/M. It sits beside the bypass unit and drives the PC, F/D, D/X and X/M latch enables and NOP muxes.

---
 rtl/stall_control.sv | 193 +++++++++++++++++++
 tb/tb_stall_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_control.sv
// Load-use bubble insertion and multdiv launch/wait sequencing for the 5-stage core.
// Drives the PC, F/D, D/X and X/M hold/NOP controls and holds the multdiv result for X/M.
//
// state | meaning
// IDLE  | no multdiv op in flight; launches when a mul/div sits in D/X
// START | one-cycle ctrl_MULT/ctrl_DIV pulse to the multdiv unit
// BUSY  | waiting for data_resultRDY, counting cycles toward the timeout
// DONE  | md_result/md_exc valid for X/M; D/X released at end of cycle
module stall_control #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_ir,
    input  logic [31:0] dx_ir,
    input  logic        flush,
    input  logic        data_resultRDY,
    input  logic        data_exception,
    input  logic [31:0] data_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall_front,
    output logic        stall_dx,
    output logic        nop_dx,
    output logic        nop_xm,
    output logic        md_valid,
    output logic [31:0] md_result,
    output logic        md_exc
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [31:0]       md_result_q, md_result_d;
    logic              md_exc_q, md_exc_d;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic       dx_md;
    logic       src_a_vld, src_b_vld;
    logic [4:0] src_b;
    logic       lu_stall;
    logic       md_stall;
    logic       unused_ir_bits;

    assign fd_op  = fd_ir[31:27];
    assign fd_rd  = fd_ir[26:22];
    assign fd_rs  = fd_ir[21:17];
    assign fd_rt  = fd_ir[16:12];
    assign dx_op  = dx_ir[31:27];
    assign dx_rd  = dx_ir[26:22];
    assign dx_alu = dx_ir[6:2];

    assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    assign dx_md = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));

    // Which F/D register fields are actually read, so a lw only stalls true consumers.
    always_comb begin
        src_a_vld = 1'b1;
        src_b_vld = 1'b0;
        src_b     = fd_rt;
        if ((fd_op == OP_J) || (fd_op == OP_JAL) || (fd_op == OP_SETX) || (fd_op == OP_BEX)) begin
            src_a_vld = 1'b0;
        end
        case (fd_op)
            OP_RTYPE: begin
                src_b_vld = 1'b1;
                src_b     = fd_rt;
            end
            OP_SW, OP_BNE, OP_BLT, OP_JR: begin
                src_b_vld = 1'b1;
                src_b     = fd_rd;
            end
            OP_BEX: begin
                src_b_vld = 1'b1;
                src_b     = REG_RSTATUS;
            end
            default: begin
                src_b_vld = 1'b0;
            end
        endcase
    end

    always_comb begin
        lu_stall = 1'b0;
        if (!reset && (dx_op == OP_LW) && (dx_rd != 5'd0)) begin
            lu_stall = (src_a_vld && (fd_rs == dx_rd)) || (src_b_vld && (src_b == dx_rd));
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        md_result_d = md_result_q;
        md_exc_d    = md_exc_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (dx_md && !flush) begin
                    state_d  = ST_START;
                    is_div_d = (dx_alu == ALU_DIV);
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = flush ? ST_IDLE : ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Flush wins over a same-cycle result: the op is squashed and nothing is latched.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (data_resultRDY) begin
                    state_d     = ST_DONE;
                    md_result_d = data_result;
                    md_exc_d    = data_exception;
                end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                    state_d     = ST_DONE;
                    md_result_d = '0;
                    md_exc_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            md_result_q <= '0;
            md_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            md_result_q <= md_result_d;
            md_exc_q    <= md_exc_d;
        end
    end

    // The launch cycle itself must already freeze the front, before START is registered.
    always_comb begin
        md_stall = 1'b0;
        if (!reset) begin
            md_stall = ((state_q == ST_IDLE) && dx_md && !flush)
                     || (state_q == ST_START)
                     || (state_q == ST_BUSY);
        end
    end

    assign ctrl_MULT   = (state_q == ST_START) && !is_div_q;
    assign ctrl_DIV    = (state_q == ST_START) && is_div_q;
    assign md_valid    = (state_q == ST_DONE);
    assign md_result   = md_result_q;
    assign md_exc      = md_exc_q;

    assign stall_front = md_stall | lu_stall;
    assign stall_dx    = md_stall;
    assign nop_xm      = md_stall;
    assign nop_dx      = lu_stall & ~md_stall;

endmodule

// File: tb/tb_stall_control.sv
// Self-checking bench for stall_control: load-use decode table, mul/div sequencing,
// timeout, flush and reset abort; md results checked through an expected-result queue.
module tb_stall_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_ir = '0;
    logic [31:0] dx_ir = '0;
    logic        flush = 1'b0;
    logic        data_resultRDY = 1'b0;
    logic        data_exception = 1'b0;
    logic [31:0] data_result = '0;
    logic        ctrl_MULT, ctrl_DIV, stall_front, stall_dx, nop_dx, nop_xm, md_valid, md_exc;
    logic [31:0] md_result;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   mult_times[$];
    int   div_pulses = 0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    stall_control #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .fd_ir          (fd_ir),
        .dx_ir          (dx_ir),
        .flush          (flush),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .data_result    (data_result),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .stall_front    (stall_front),
        .stall_dx       (stall_dx),
        .nop_dx         (nop_dx),
        .nop_xm         (nop_xm),
        .md_valid       (md_valid),
        .md_result      (md_result),
        .md_exc         (md_exc)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Scoreboard side: every md_valid must match the oldest pushed expectation.
    always @(negedge clock) begin
        if (md_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_result", md_result, e.res);
                chk("sb_exc", {31'd0, md_exc}, {31'd0, e.exc});
            end
        end
        if (ctrl_MULT === 1'b1) mult_times.push_back(cyc);
        if (ctrl_DIV === 1'b1) div_pulses++;
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {24'd0, ctrl_MULT, ctrl_DIV, stall_front, stall_dx, nop_dx, nop_xm, md_valid, md_exc}, 32'd0);
        chk({tag, "_res"}, md_result, 32'd0);
    endtask

    // Caller is positioned in the launch cycle (state IDLE); returns in the DONE cycle.
    task automatic run_md(input string tag, input logic [31:0] ir, input logic is_div,
                          input logic [31:0] res, input logic exc, input int rdy_after);
        exp_t e;
        dx_ir = ir;
        fd_ir = '0;
        #1;
        chk({tag, "_stall_t"}, {31'd0, stall_front}, 32'd1);
        chk({tag, "_nopxm_t"}, {31'd0, nop_xm}, 32'd1);
        tick;
        #1;
        chk({tag, "_start"}, {30'd0, ctrl_MULT, ctrl_DIV}, {30'd0, !is_div, is_div});
        chk({tag, "_stall_s"}, {31'd0, stall_front}, 32'd1);
        for (int i = 1; i <= rdy_after; i++) begin
            tick;
            if (i == rdy_after) begin
                data_resultRDY = 1'b1;
                data_result    = res;
                data_exception = exc;
                e.res = res;
                e.exc = exc;
                sb_q.push_back(e);
            end
            #1;
            chk({tag, "_busy_ctrl"}, {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
            chk({tag, "_busy_stall"}, {31'd0, stall_front}, 32'd1);
        end
        tick;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        #1;
        chk({tag, "_done_valid"}, {31'd0, md_valid}, 32'd1);
        chk({tag, "_done_res"}, md_result, res);
        chk({tag, "_done_stall"}, {31'd0, stall_front}, 32'd0);
    endtask

    logic [31:0] lu_fd[11];
    logic [31:0] lu_dx[11];
    logic        lu_exp[11];

    initial begin
        logic [31:0] mul1, mul2, div1, lw5, lw0, lw30, nop;
        int vld_seen;
        int last_stall;
        exp_t e;

        nop  = 32'd0;
        mul1 = mk_r(5'd3, 5'd1, 5'd2, 5'b00110);
        mul2 = mk_r(5'd4, 5'd3, 5'd1, 5'b00110);
        div1 = mk_r(5'd7, 5'd1, 5'd2, 5'b00111);
        lw5  = mk_i(5'b01000, 5'd5, 5'd2, 17'd0);
        lw0  = mk_i(5'b01000, 5'd0, 5'd2, 17'd0);
        lw30 = mk_i(5'b01000, 5'd30, 5'd2, 17'd0);

        lu_dx[0] = lw5;  lu_fd[0]  = mk_r(5'd6, 5'd5, 5'd1, 5'd0);             lu_exp[0]  = 1'b1;
        lu_dx[1] = nop;  lu_fd[1]  = mk_r(5'd6, 5'd5, 5'd1, 5'd0);             lu_exp[1]  = 1'b0;
        lu_dx[2] = lw0;  lu_fd[2]  = mk_r(5'd6, 5'd0, 5'd1, 5'd0);             lu_exp[2]  = 1'b0;
        lu_dx[3] = lw5;  lu_fd[3]  = mk_r(5'd6, 5'd1, 5'd5, 5'd0);             lu_exp[3]  = 1'b1;
        lu_dx[4] = lw5;  lu_fd[4]  = mk_i(5'b00111, 5'd5, 5'd7, 17'd0);       lu_exp[4]  = 1'b1;
        lu_dx[5] = lw5;  lu_fd[5]  = mk_i(5'b00101, 5'd5, 5'd1, 17'd4);       lu_exp[5]  = 1'b0;
        lu_dx[6] = lw5;  lu_fd[6]  = mk_i(5'b00011, 5'd0, 5'd5, 17'd0);       lu_exp[6]  = 1'b0;
        lu_dx[7] = lw5;  lu_fd[7]  = mk_i(5'b00100, 5'd5, 5'd0, 17'd0);       lu_exp[7]  = 1'b1;
        lu_dx[8] = lw30; lu_fd[8]  = mk_i(5'b10110, 5'd0, 5'd0, 17'd0);       lu_exp[8]  = 1'b1;
        lu_dx[9] = lw5;  lu_fd[9]  = mk_i(5'b10110, 5'd0, 5'd5, 17'd0);       lu_exp[9]  = 1'b0;
        lu_dx[10] = lw5; lu_fd[10] = mk_i(5'b00110, 5'd5, 5'd1, 17'd0);       lu_exp[10] = 1'b1;

        // Reset held two edges with a mul in D/X, then the mul runs with RDY at t+2.
        dx_ir = mul1;
        tick;
        #1;
        chk_all_zero("rst_c1");
        tick;
        #1;
        chk_all_zero("rst_c2");
        reset = 1'b0;
        run_md("mul_rst", mul1, 1'b0, 32'h0000_0030, 1'b0, 1);
        tick;
        dx_ir = nop;
        #1;
        chk("idle_after_mul", {31'd0, stall_front}, 32'd0);

        // div with no RDY: times out after 40 BUSY cycles.
        tick;
        dx_ir = div1;
        e.res = 32'd0;
        e.exc = 1'b1;
        sb_q.push_back(e);
        #1;
        chk("div_stall_t", {31'd0, stall_front}, 32'd1);
        vld_seen = 0;
        last_stall = 0;
        for (int i = 1; i <= 41; i++) begin
            tick;
            #1;
            if (md_valid === 1'b1) vld_seen++;
            if (i == 41) last_stall = int'(stall_front);
        end
        chk("div_no_early_valid", vld_seen, 32'd0);
        chk("div_last_busy_stall", last_stall, 32'd1);
        tick;
        #1;
        chk("div_to_valid", {31'd0, md_valid}, 32'd1);
        chk("div_to_exc", {31'd0, md_exc}, 32'd1);
        chk("div_to_res", md_result, 32'd0);
        chk("div_pulses", div_pulses, 32'd1);
        tick;
        dx_ir = nop;

        // Load-use decode table; entry 1 is the cycle after the bubble.
        for (int i = 0; i < 11; i++) begin
            dx_ir = lu_dx[i];
            fd_ir = lu_fd[i];
            #1;
            chk($sformatf("lu%0d_front", i), {31'd0, stall_front}, {31'd0, lu_exp[i]});
            chk($sformatf("lu%0d_nopdx", i), {31'd0, nop_dx}, {31'd0, lu_exp[i]});
            chk($sformatf("lu%0d_dx", i), {31'd0, stall_dx}, 32'd0);
            tick;
        end
        dx_ir = nop;
        fd_ir = nop;

        // Flush: blocks a launch in IDLE, then aborts BUSY even with same-cycle RDY.
        tick;
        dx_ir = mul1;
        flush = 1'b1;
        #1;
        chk("flush_idle_nostall", {31'd0, stall_front}, 32'd0);
        tick;
        flush = 1'b0;
        #1;
        chk("flush_idle_nostart", {31'd0, ctrl_MULT}, 32'd0);
        tick;
        tick;
        tick;
        flush = 1'b1;
        data_resultRDY = 1'b1;
        data_result = 32'h0000_DEAD;
        data_exception = 1'b0;
        #1;
        chk("flush_busy_stall", {31'd0, stall_front}, 32'd1);
        tick;
        flush = 1'b0;
        data_resultRDY = 1'b0;
        dx_ir = nop;
        #1;
        chk("flush_valid", {31'd0, md_valid}, 32'd0);
        chk("flush_res_held", md_result, 32'd0);
        chk("flush_exc_held", {31'd0, md_exc}, 32'd1);
        chk("flush_idle_stall", {31'd0, stall_front}, 32'd0);
        tick;
        #1;
        chk("flush_valid2", {31'd0, md_valid}, 32'd0);

        // Reset in BUSY, then a late RDY that must be ignored.
        tick;
        dx_ir = mul1;
        tick;
        tick;
        reset = 1'b1;
        #1;
        tick;
        reset = 1'b0;
        dx_ir = nop;
        #1;
        chk_all_zero("rstmid");
        data_resultRDY = 1'b1;
        data_result = 32'h0000_0055;
        tick;
        data_resultRDY = 1'b0;
        #1;
        chk("rstmid_late_rdy", {31'd0, md_valid}, 32'd0);

        // Back-to-back muls, RDY four cycles after each start pulse.
        tick;
        run_md("b2b1", mul1, 1'b0, 32'h0000_0111, 1'b0, 4);
        tick;
        run_md("b2b2", mul2, 1'b0, 32'h0000_0222, 1'b0, 4);
        tick;
        dx_ir = nop;
        tick;
        chk("mult_pulse_count", mult_times.size(), 32'd5);
        if (mult_times.size() >= 2) begin
            chk("b2b_spacing", mult_times[mult_times.size()-1] - mult_times[mult_times.size()-2], 32'd7);
        end else begin
            chk("b2b_spacing_missing", mult_times.size(), 32'd2);
        end
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
